// File: rtl/perf_tx_pkg.sv
// Shared state codes, message constants and hex formatting for the perf UART reporter.
package perf_tx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t START  = 3'd1;
    localparam state_t DATA   = 3'd2;
    localparam state_t PARITY = 3'd3;
    localparam state_t STOP   = 3'd4;
    localparam state_t FINISH = 3'd5;

    localparam int MSG_LEN = 19;

    localparam logic [7:0] ASC_C  = 8'h43;
    localparam logic [7:0] ASC_EQ = 8'h3D;
    localparam logic [7:0] ASC_SP = 8'h20;
    localparam logic [7:0] ASC_T  = 8'h54;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;

    function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// One-byte UART transmitter, LSB first, with back-to-back frames and no idle gap.
// Build with PERF_TX_PARITY_EN defined to insert an even-parity bit before the stop bit.
module uart_tx_byte
    import perf_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLK_50,
    input  logic       resetN,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       uart_tx
);

    localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 1);

    state_t      state;
    logic [15:0] timer;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        bit_end;
`ifdef PERF_TX_PARITY_EN
    logic        par;
`endif

    assign bit_end  = (timer == LAST_TICK);
    assign tx_done  = (state == STOP) && bit_end;
    // A new byte is taken on the last stop-bit cycle so the next start bit follows directly.
    assign tx_ready = (state == IDLE) || tx_done;

    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
`ifdef PERF_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            if (state == IDLE || bit_end)
                timer <= '0;
            else
                timer <= timer + 16'd1;

            case (state)
                IDLE, STOP: begin
                    if (tx_ready) begin
                        if (tx_start) begin
                            state   <= START;
                            shift   <= tx_data;
                            uart_tx <= 1'b0;
`ifdef PERF_TX_PARITY_EN
                            par     <= ^tx_data;
`endif
                        end else begin
                            state   <= IDLE;
                            uart_tx <= 1'b1;
                        end
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        uart_tx <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
`ifdef PERF_TX_PARITY_EN
                            state   <= PARITY;
                            uart_tx <= par;
`else
                            state   <= STOP;
                            uart_tx <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            uart_tx <= shift[1];
                        end
                    end
                end
`ifdef PERF_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state   <= STOP;
                        uart_tx <= 1'b1;
                    end
                end
`endif
                default: begin
                    state   <= IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/perf_uart_reporter.sv
// Snapshots the perf counters on a request edge and prints "C=xxxxxxxx T=xxxx\r\n" over UART.
// Frame format follows uart_tx_byte (8N1, or 8E1 with PERF_TX_PARITY_EN).
module perf_uart_reporter
    import perf_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 32,
    parameter int HUND_W       = 13
) (
    input  logic              CLK_50,
    input  logic              resetN,
    input  logic              report_req,
    input  logic [CNT_W-1:0]  clk_count,
    input  logic [HUND_W-1:0] hund_count,
    output logic              uart_tx,
    output logic              busy,
    output logic              done
);

    localparam logic [4:0] LAST_CHAR = 5'(MSG_LEN - 1);

    state_t      state;
    logic        req_q;
    logic        req_edge;
    logic [31:0] snap_clk;
    logic [15:0] snap_hund;
    logic [4:0]  char_idx;
    logic [4:0]  sel_idx;
    logic [2:0]  clk_nib;
    logic [1:0]  hund_nib;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_ready;
    logic        tx_done;

    assign req_edge = report_req & ~req_q;
    assign busy     = (state == START) || (state == DATA);
    assign done     = (state == FINISH);

    // While streaming, the byte offered to the transmitter is the one after the current char.
    assign sel_idx  = (state == DATA) ? char_idx + 5'd1 : char_idx;
    assign tx_start = ((state == START) && tx_ready) ||
                      ((state == DATA) && tx_done && (char_idx != LAST_CHAR));

    assign clk_nib  = 3'(5'd9 - sel_idx);
    assign hund_nib = 2'(5'd16 - sel_idx);

    always_comb begin
        tx_data = 8'h00;
        if (sel_idx == 5'd0)
            tx_data = ASC_C;
        else if (sel_idx == 5'd1)
            tx_data = ASC_EQ;
        else if (sel_idx <= 5'd9)
            tx_data = hex_to_ascii(snap_clk[{clk_nib, 2'b00} +: 4]);
        else if (sel_idx == 5'd10)
            tx_data = ASC_SP;
        else if (sel_idx == 5'd11)
            tx_data = ASC_T;
        else if (sel_idx == 5'd12)
            tx_data = ASC_EQ;
        else if (sel_idx <= 5'd16)
            tx_data = hex_to_ascii(snap_hund[{hund_nib, 2'b00} +: 4]);
        else if (sel_idx == 5'd17)
            tx_data = ASC_CR;
        else if (sel_idx == 5'd18)
            tx_data = ASC_LF;
    end

    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            req_q     <= 1'b0;
            snap_clk  <= '0;
            snap_hund <= '0;
            char_idx  <= '0;
        end else begin
            req_q <= report_req;
            case (state)
                IDLE: begin
                    if (req_edge) begin
                        snap_clk  <= 32'(clk_count);
                        snap_hund <= 16'(hund_count);
                        char_idx  <= '0;
                        state     <= START;
                    end
                end
                START: begin
                    if (tx_ready)
                        state <= DATA;
                end
                DATA: begin
                    if (tx_done) begin
                        if (char_idx == LAST_CHAR)
                            state <= FINISH;
                        else
                            char_idx <= char_idx + 5'd1;
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .CLK_50  (CLK_50),
        .resetN  (resetN),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx_ready(tx_ready),
        .tx_done (tx_done),
        .uart_tx (uart_tx)
    );

endmodule

// File: tb/tb_perf_uart_reporter.sv
// Directed bench: expected report bytes are queued at request time and checked by a UART receiver.
module tb_perf_uart_reporter;

    localparam int CPB = 4;
`ifdef PERF_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif

    logic        CLK_50 = 1'b0;
    logic        resetN;
    logic        report_req;
    logic [31:0] clk_count;
    logic [12:0] hund_count;
    logic        uart_tx;
    logic        busy;
    logic        done;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         rx_cnt = 0;
    bit         rx_en = 1'b0;
    logic [7:0] exp_q[$];

    always #10 CLK_50 = ~CLK_50;
    always @(posedge CLK_50) cyc <= cyc + 1;

    perf_uart_reporter #(
        .CLKS_PER_BIT(CPB),
        .CNT_W(32),
        .HUND_W(13)
    ) dut (
        .CLK_50    (CLK_50),
        .resetN    (resetN),
        .report_req(report_req),
        .clk_count (clk_count),
        .hund_count(hund_count),
        .uart_tx   (uart_tx),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hx(input logic [3:0] n);
        logic [7:0] v;
        v = {4'h0, n};
        return (n < 4'd10) ? (8'h30 + v) : (8'h41 + v - 8'd10);
    endfunction

    task automatic push_msg(input logic [31:0] c, input logic [15:0] h);
        exp_q.push_back(8'h43);
        exp_q.push_back(8'h3D);
        for (int i = 7; i >= 0; i--) exp_q.push_back(hx(c[i*4 +: 4]));
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h54);
        exp_q.push_back(8'h3D);
        for (int i = 3; i >= 0; i--) exp_q.push_back(hx(h[i*4 +: 4]));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Raises the request at a falling edge; busy must be up on the next falling edge.
    task automatic start_report(input logic [31:0] c, input logic [12:0] h, output int cs);
        push_msg(c, {3'b000, h});
        clk_count  = c;
        hund_count = h;
        report_req = 1'b1;
        @(negedge CLK_50);
        chk("busy_on_edge", {63'd0, busy}, 64'd1);
        cs = cyc;
    endtask

    task automatic wait_done(input int cs, input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20000) begin
            @(negedge CLK_50);
            n++;
        end
        chk({tag, "_done_cycle"}, 64'(cyc - cs - 1), 64'(FRAME * 19 * CPB));
        chk({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
        @(negedge CLK_50);
        chk({tag, "_done_one_cycle"}, {63'd0, done}, 64'd0);
    endtask

    task automatic settle(input int base, input int nchars, input string tag);
        repeat (FRAME * CPB + 20) @(negedge CLK_50);
        chk({tag, "_rx_count"}, 64'(rx_cnt - base), 64'(nchars));
        chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
    endtask

    // UART receiver: mid-bit sampling on falling edges.
    initial begin : rx
        logic [7:0] b;
        logic [7:0] e;
        logic       p;
        logic       s;
        p = 1'b0;
        forever begin
            @(negedge CLK_50);
            if (resetN === 1'b1 && uart_tx === 1'b0) begin
                repeat (CPB + CPB / 2 - 1) @(negedge CLK_50);
                b[0] = uart_tx;
                for (int i = 1; i < 8; i++) begin
                    repeat (CPB) @(negedge CLK_50);
                    b[i] = uart_tx;
                end
`ifdef PERF_TX_PARITY_EN
                repeat (CPB) @(negedge CLK_50);
                p = uart_tx;
`endif
                repeat (CPB) @(negedge CLK_50);
                s = uart_tx;
                if (rx_en) begin
                    rx_cnt++;
                    e = 8'hxx;
                    if (exp_q.size() > 0) e = exp_q.pop_front();
                    chk("rx_byte", {56'd0, b}, {56'd0, e});
                    chk("rx_stop", {63'd0, s}, 64'd1);
`ifdef PERF_TX_PARITY_EN
                    chk("rx_parity", {63'd0, p}, {63'd0, ^b});
`endif
                end
            end
        end
    end

    initial begin : main
        int cs;
        int cs2;
        int base;
        int n;
        int errs;
        resetN     = 1'b0;
        report_req = 1'b0;
        clk_count  = '0;
        hund_count = '0;
        repeat (5) @(negedge CLK_50);
        chk("reset_outputs", {61'd0, uart_tx, busy, done}, 64'b100);

        resetN = 1'b1;
        rx_en  = 1'b1;
        errs   = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK_50);
            if ({uart_tx, busy, done} !== 3'b100) errs++;
        end
        chk("idle_1000", 64'(errs), 64'd0);

        // Basic report with a second edge while busy, which must be dropped
        base = rx_cnt;
        start_report(32'h0001_2ABF, 13'h04D2, cs);
        report_req = 1'b0;
        repeat (100) @(negedge CLK_50);
        report_req = 1'b1;
        @(negedge CLK_50);
        chk("busy_during_extra_edge", {63'd0, busy}, 64'd1);
        report_req = 1'b0;
        wait_done(cs, "basic");
        settle(base, 19, "basic");

        // Request held high for 2000 cycles gives a single report
        base = rx_cnt;
        start_report(32'hDEAD_BEEF, 13'h1234, cs);
        wait_done(cs, "hold");
        while (cyc - cs < 2000) @(negedge CLK_50);
        report_req = 1'b0;
        settle(base, 19, "hold");

        // Second edge on the cycle after done starts a new report
        base = rx_cnt;
        start_report(32'h89AB_CDEF, 13'h0ABC, cs);
        report_req = 1'b0;
        wait_done(cs, "b2b_a");
        start_report(32'h7654_3210, 13'h1000, cs2);
        report_req = 1'b0;
        wait_done(cs2, "b2b_b");
        settle(base, 38, "b2b");

        // Inputs change mid-report; printed digits come from the snapshot
        base = rx_cnt;
        start_report(32'h0BAD_F00D, 13'h0777, cs);
        report_req = 1'b0;
        repeat (200) @(negedge CLK_50);
        clk_count  = 32'hFFFF_FFFF;
        hund_count = '1;
        wait_done(cs, "snap");
        settle(base, 19, "snap");

        // Reset during the data bits of char 5
        base = rx_cnt;
        start_report(32'hCAFE_0001, 13'h0042, cs);
        report_req = 1'b0;
        n = 0;
        while (rx_cnt - base < 5 && n < 5000) begin
            @(negedge CLK_50);
            n++;
        end
        chk("reach_char5", 64'(rx_cnt - base), 64'd5);
        repeat (8) @(negedge CLK_50);
        chk("busy_before_reset", {63'd0, busy}, 64'd1);
        rx_en  = 1'b0;
        resetN = 1'b0;
        #1;
        chk("reset_tx_high", {63'd0, uart_tx}, 64'd1);
        chk("reset_busy_low", {63'd0, busy}, 64'd0);
        chk("reset_done_low", {63'd0, done}, 64'd0);
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK_50);
            if (done !== 1'b0 || uart_tx !== 1'b1) errs++;
        end
        resetN = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK_50);
            if (done !== 1'b0 || uart_tx !== 1'b1 || busy !== 1'b0) errs++;
        end
        chk("reset_quiet", 64'(errs), 64'd0);
        exp_q.delete();
        rx_en = 1'b1;

        // Clean report after reset: zero count and maximum hundredths
        base = rx_cnt;
        start_report(32'h0000_0000, 13'h1FFF, cs);
        report_req = 1'b0;
        wait_done(cs, "post_reset");
        settle(base, 19, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
